// File: rtl/reg_transfer_sequencer.sv
`default_nettype none
// reg_transfer_sequencer: sequences select/load strobes for register-transfer instructions.
// Revision: 1.0

module reg_transfer_sequencer #(
    parameter int SETUP_CYC = 2,
    parameter int LOAD_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [7:0] data_sel,
    output logic [7:0] data_ld,
    output logic       imm_oe,
    output logic [7:0] imm_data,
    output logic       addr_sel_m,
    output logic       ld_xy
);

    localparam int MAX_CYC = (SETUP_CYC > LOAD_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((LOAD_CYC  > HOLD_CYC) ? LOAD_CYC  : HOLD_CYC);
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] LOAD_LD  = CNT_W'(LOAD_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_MOV8  = 2'd0,
        OP_SETAB = 2'd1,
        OP_MOV16 = 2'd2,
        OP_NONE  = 2'd3
    } op_t;

    // OP_NONE covers both the same-register NOP and unsupported encodings.
    function automatic op_t decode_op(input logic [7:0] ins);
        op_t op;
        op = OP_NONE;
        if (ins[7:6] == 2'b00) begin
            if (ins[5:3] != ins[2:0]) op = OP_MOV8;
        end else if (ins[7:6] == 2'b01) begin
            op = OP_SETAB;
        end else if (ins == 8'h80) begin
            op = OP_MOV16;
        end
        return op;
    endfunction

    function automatic logic is_illegal(input logic [7:0] ins);
        return !((ins[7:6] == 2'b00) || (ins[7:6] == 2'b01) || (ins == 8'h80));
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       instr_q, instr_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;
    logic [7:0] sel_q, sel_d;
    logic [7:0] ld_q, ld_d;
    logic       imm_oe_q, imm_oe_d;
    logic [7:0] imm_q, imm_d;
    logic       asm_q, asm_d;
    logic       lxy_q, lxy_d;

    op_t  op_d;
    logic src_on;
    logic ld_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    if (decode_op(instr) != OP_NONE) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_LOAD;
                    cnt_d   = LOAD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with no extra latency.
    always_comb begin
        op_d      = decode_op(instr_d);
        src_on    = (state_d == S_SETUP) || (state_d == S_LOAD) || (state_d == S_HOLD);
        ld_on     = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        illegal_d = (state_d == S_DONE) && is_illegal(instr_d);
        sel_d     = 8'h00;
        ld_d      = 8'h00;
        imm_oe_d  = 1'b0;
        imm_d     = 8'h00;
        asm_d     = 1'b0;
        lxy_d     = 1'b0;
        unique case (op_d)
            OP_MOV8: begin
                if (src_on) sel_d = 8'd1 << instr_d[2:0];
                if (ld_on)  ld_d  = 8'd1 << instr_d[5:3];
            end
            OP_SETAB: begin
                imm_oe_d = src_on;
                if (src_on) imm_d = {{3{instr_d[4]}}, instr_d[4:0]};
                if (ld_on)  ld_d  = instr_d[5] ? 8'h02 : 8'h01;
            end
            OP_MOV16: begin
                asm_d = src_on;
                lxy_d = ld_on;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            instr_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            sel_q     <= 8'h00;
            ld_q      <= 8'h00;
            imm_oe_q  <= 1'b0;
            imm_q     <= 8'h00;
            asm_q     <= 1'b0;
            lxy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            sel_q     <= sel_d;
            ld_q      <= ld_d;
            imm_oe_q  <= imm_oe_d;
            imm_q     <= imm_d;
            asm_q     <= asm_d;
            lxy_q     <= lxy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign illegal    = illegal_q;
    assign data_sel   = sel_q;
    assign data_ld    = ld_q;
    assign imm_oe     = imm_oe_q;
    assign imm_data   = imm_q;
    assign addr_sel_m = asm_q;
    assign ld_xy      = lxy_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_transfer_sequencer.sv
`default_nettype none
// tb_reg_transfer_sequencer: scoreboard bench for a default-timing and a minimum-timing sequencer.
// Revision: 1.0

module tb_reg_transfer_sequencer;

    typedef struct packed {
        logic       ill;
        int         lat;
        int         src_n;
        int         ld_n;
        int         first_ld;
        int         abort_cyc;
        logic [7:0] sel;
        logic [7:0] ld;
        logic [7:0] imm;
        logic       ioe;
        logic       asm;
        logic       lxy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_r [2];
    logic [7:0] instr_r;
    logic       abort_r;

    logic       busy_w [2];
    logic       done_w [2];
    logic       ill_w  [2];
    logic [7:0] sel_w  [2];
    logic [7:0] ld_w   [2];
    logic       ioe_w  [2];
    logic [7:0] imm_w  [2];
    logic       asm_w  [2];
    logic       lxy_w  [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    int         cyc      [2];
    int         src_n    [2];
    int         ld_n     [2];
    int         first_ld [2];
    logic [7:0] sel_or   [2];
    logic [7:0] ld_or    [2];
    logic [7:0] imm_or   [2];
    logic       ioe_or   [2];
    logic       asm_or   [2];
    logic       lxy_or   [2];

    reg_transfer_sequencer #(.SETUP_CYC(2), .LOAD_CYC(2), .HOLD_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .instr(instr_r), .abort(abort_r),
        .busy(busy_w[0]), .done(done_w[0]), .illegal(ill_w[0]), .data_sel(sel_w[0]),
        .data_ld(ld_w[0]), .imm_oe(ioe_w[0]), .imm_data(imm_w[0]),
        .addr_sel_m(asm_w[0]), .ld_xy(lxy_w[0])
    );

    reg_transfer_sequencer #(.SETUP_CYC(1), .LOAD_CYC(1), .HOLD_CYC(1)) u_dut_min (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .instr(instr_r), .abort(abort_r),
        .busy(busy_w[1]), .done(done_w[1]), .illegal(ill_w[1]), .data_sel(sel_w[1]),
        .data_ld(ld_w[1]), .imm_oe(ioe_w[1]), .imm_data(imm_w[1]),
        .addr_sel_m(asm_w[1]), .ld_xy(lxy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: what an instruction should produce, from the instruction rules and phase lengths.
    function automatic exp_t model(input logic [7:0] ins, input int su, input int lc,
                                   input int hc, input int ab);
        exp_t e;
        int   s;
        int   t;
        int   v;
        logic legal;
        e     = '0;
        legal = 1'b0;
        s     = int'(ins[2:0]);
        t     = int'(ins[5:3]);
        v     = int'(ins[4:0]);
        if (ins[7:6] == 2'b00) begin
            if (s != t) begin
                legal = 1'b1;
                e.sel = 8'(1 << s);
                e.ld  = 8'(1 << t);
            end
        end else if (ins[7:6] == 2'b01) begin
            if (v >= 16) v = v - 32;
            legal = 1'b1;
            e.ioe = 1'b1;
            e.imm = 8'(v);
            e.ld  = ins[5] ? 8'h02 : 8'h01;
        end else if (ins == 8'h80) begin
            legal = 1'b1;
            e.asm = 1'b1;
            e.lxy = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        if (legal) begin
            e.lat       = su + lc + hc + 1;
            e.src_n     = su + lc + hc;
            e.ld_n      = lc;
            e.first_ld  = su + 1;
            e.abort_cyc = ab;
        end else begin
            e.lat = 1;
        end
        return e;
    endfunction

    function automatic logic [35:0] all_outs(input int d);
        return {busy_w[d], done_w[d], ill_w[d], sel_w[d], ld_w[d], ioe_w[d], imm_w[d],
                asm_w[d], lxy_w[d]};
    endfunction

    // Monitor: accumulates each operation's strobe profile and scores it when it finishes.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                cyc[d] = 0;
            end else begin
                ok = $onehot0(sel_w[d]) && $onehot0(ld_w[d])
                     && !((sel_w[d] != 8'h00) && (ioe_w[d] || asm_w[d]))
                     && !((ld_w[d] != 8'h00) && (sel_w[d] == 8'h00) && !ioe_w[d])
                     && !(lxy_w[d] && !asm_w[d])
                     && (ioe_w[d] || (imm_w[d] == 8'h00))
                     && !(ill_w[d] && !done_w[d])
                     && (busy_w[d] || (all_outs(d) == 36'h0));
                check($sformatf("d%0d_invariant outs=0x%0h", d, all_outs(d)), 64'(ok), 64'(1));

                if (busy_w[d]) begin
                    if (cyc[d] == 0) begin
                        src_n[d] = 0; ld_n[d] = 0; first_ld[d] = 0;
                        sel_or[d] = 8'h00; ld_or[d] = 8'h00; imm_or[d] = 8'h00;
                        ioe_or[d] = 1'b0; asm_or[d] = 1'b0; lxy_or[d] = 1'b0;
                        check($sformatf("d%0d_expected_op_pending", d),
                              64'(((d == 0) ? q0.size() : q1.size()) != 0), 64'(1));
                    end
                    cyc[d]++;
                    if ((sel_w[d] != 8'h00) || ioe_w[d] || asm_w[d]) src_n[d]++;
                    if ((ld_w[d] != 8'h00) || lxy_w[d]) begin
                        ld_n[d]++;
                        if (first_ld[d] == 0) first_ld[d] = cyc[d];
                    end
                    sel_or[d] |= sel_w[d];
                    ld_or[d]  |= ld_w[d];
                    imm_or[d] |= imm_w[d];
                    ioe_or[d] |= ioe_w[d];
                    asm_or[d] |= asm_w[d];
                    lxy_or[d] |= lxy_w[d];
                    if (done_w[d] && (((d == 0) ? q0.size() : q1.size()) != 0)) begin
                        e = (d == 0) ? q0[0] : q1[0];
                        check($sformatf("d%0d_aborted_op_completed", d), 64'(0), 64'(e.abort_cyc));
                        check($sformatf("d%0d_done_cycle", d), 64'(cyc[d]), 64'(e.lat));
                        check($sformatf("d%0d_illegal", d), 64'(ill_w[d]), 64'(e.ill));
                        check($sformatf("d%0d_src_cycles", d), 64'(src_n[d]), 64'(e.src_n));
                        check($sformatf("d%0d_ld_cycles", d), 64'(ld_n[d]), 64'(e.ld_n));
                        check($sformatf("d%0d_first_ld_cycle", d), 64'(first_ld[d]), 64'(e.first_ld));
                        check($sformatf("d%0d_strobes{sel,ld,imm,oe,m,xy}", d),
                              64'({sel_or[d], ld_or[d], imm_or[d], ioe_or[d], asm_or[d], lxy_or[d]}),
                              64'({e.sel, e.ld, e.imm, e.ioe, e.asm, e.lxy}));
                        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        cyc[d] = 0;
                    end
                end else if (cyc[d] != 0) begin
                    e = (d == 0) ? q0[0] : q1[0];
                    check($sformatf("d%0d_abort_last_busy_cycle", d), 64'(cyc[d]), 64'(e.abort_cyc));
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    cyc[d] = 0;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of cycle 4 after the start.
    task automatic issue(input logic [7:0] ins, input int ab);
        exp_t e0;
        exp_t e1;
        logic pulse;
        int   w;
        w = 0;
        while ((busy_w[0] || busy_w[1]) && (w < 50)) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("idle_wait_timeout", 64'(w), 64'(0));
        e0 = model(ins, 2, 2, 1, ab);
        e1 = model(ins, 1, 1, 1, ab);
        q0.push_back(e0);
        q1.push_back(e1);
        pulse = (e0.lat > 1) && ((ab == 0) || (ab >= 2));
        instr_r    = ins;
        start_r[0] = 1'b1;
        start_r[1] = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            start_r[0] = pulse && (c == 2);
            start_r[1] = pulse && (c == 2);
            abort_r    = (c == ab);
            instr_r    = 8'($urandom);
            @(negedge clk);
        end
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        abort_r    = 1'b0;
    endtask

    initial begin
        logic [7:0] ins;
        int         k;
        int         ab;
        int         w;
        rst_n      = 1'b0;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        instr_r    = 8'h00;
        abort_r    = 1'b0;
        #12;
        check("reset_outs_d0", 64'(all_outs(0)), 64'(0));
        check("reset_outs_d1", 64'(all_outs(1)), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        issue(8'h11, 0);
        issue(8'h5D, 0);
        issue(8'h65, 0);
        issue(8'h80, 0);
        issue(8'hC3, 1);
        issue(8'h09, 0);
        issue(8'h18, 3);
        issue(8'h01, 0);

        // A start held only during the DONE cycle must be dropped.
        issue(8'h11, 0);
        @(negedge clk);
        @(negedge clk);
        check("done_cycle_seen_d0", 64'(done_w[0]), 64'(1));
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored_d0", 64'(busy_w[0]), 64'(0));

        // Asynchronous reset in the middle of a load.
        issue(8'h2B, 0);
        #1;
        check("mid_load_before_reset_d0", 64'(ld_w[0]), 64'(8'h20));
        rst_n = 1'b0;
        #1;
        check("async_reset_outs_d0", 64'(all_outs(0)), 64'(0));
        check("async_reset_outs_d1", 64'(all_outs(1)), 64'(0));
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset_d0", 64'(busy_w[0]), 64'(0));
        check("idle_after_reset_d1", 64'(busy_w[1]), 64'(0));

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 9));
            if (k < 4)      ins = {2'b00, 6'($urandom)};
            else if (k < 7) ins = {2'b01, 6'($urandom)};
            else if (k < 8) ins = 8'h80;
            else            ins = 8'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            issue(ins, ab);
        end

        w = 0;
        while ((busy_w[0] || busy_w[1] || (q0.size() != 0) || (q1.size() != 0)) && (w < 50)) begin
            @(negedge clk);
            w++;
        end
        check("drain_q0_empty", 64'(q0.size()), 64'(0));
        check("drain_q1_empty", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
